// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues one icache read at a time and
// buffers returned words with their PCs for the decoder.
module inst_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          LOG_QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        icache_read,
  output logic [31:0] icache_addr,
  input  logic        icache_ok,
  input  logic [31:0] icache_ans,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int L = LOG_QUEUE_DEPTH;

  localparam logic [L-1:0] PTR_ONE = L'(1);
  localparam logic [L:0]   CNT_ONE = (L + 1)'(1);
  localparam logic [L:0]   CNT_MAX = (L + 1)'(QUEUE_DEPTH);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t        state_q;
  logic          rd_q;
  logic [31:0]   addr_q;
  logic [31:0]   pc_q;
  logic          discard_q;
  logic [L-1:0]  head_q;
  logic [L-1:0]  tail_q;
  logic [L:0]    cnt_q;
  logic [L:0]    cnt_d;
  logic [31:0]   word_q [QUEUE_DEPTH];
  logic [31:0]   wpc_q  [QUEUE_DEPTH];

  logic enq;
  logic deq;
  logic space;

  assign icache_read = rd_q;
  assign icache_addr = addr_q;
  assign inst_valid  = (cnt_q != '0);
  assign inst        = word_q[head_q];
  assign inst_pc     = wpc_q[head_q];

  assign space = (cnt_q < CNT_MAX);
  assign enq   = (state_q == WAIT) && icache_ok
               && !discard_q && !jump_en;
  assign deq   = inst_valid && inst_ready && !jump_en;

  always_comb begin
    cnt_d = cnt_q;
    if (enq && !deq)
      cnt_d = cnt_q + CNT_ONE;
    else if (deq && !enq)
      cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && enq) begin
      word_q[tail_q] <= icache_ans;
      wpc_q[tail_q]  <= addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
    end else if (rdy) begin
      if (enq)
        tail_q <= tail_q + PTR_ONE;
      if (deq)
        head_q <= head_q + PTR_ONE;
      cnt_q <= cnt_d;
      // a redirect overrides any same-cycle queue movement
      if (jump_en) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
        pc_q   <= jump_addr;
      end
      unique case (state_q)
        IDLE: begin
          if (!jump_en && space) begin
            rd_q    <= 1'b1;
            addr_q  <= pc_q;
            pc_q    <= pc_q + 32'd4;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (icache_ok) begin
            rd_q      <= 1'b0;
            discard_q <= 1'b0;
            state_q   <= IDLE;
          end else if (jump_en) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised bench for inst_fetch: stream model of the expected
// instruction sequence, scoreboard plus icache protocol checks.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        icache_read;
  logic [31:0] icache_addr;
  logic        icache_ok = 1'b0;
  logic [31:0] icache_ans = '0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC       (RESET_PC),
    .QUEUE_DEPTH    (4),
    .LOG_QUEUE_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .icache_read(icache_read),
    .icache_addr(icache_addr),
    .icache_ok  (icache_ok),
    .icache_ans (icache_ans),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] exp_pc = RESET_PC;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          hs_cnt = 0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
  endtask

  // previous-cycle snapshot of inputs and outputs
  logic        p_rst = 1'b0, p_rdy = 1'b1, p_ok = 1'b0;
  logic        p_read = 1'b0, p_valid = 1'b0;
  logic [31:0] p_addr = '0, p_inst = '0, p_ipc = '0;

  always @(negedge clk) begin
    if (p_rst) begin
      chk("rst_read", {31'b0, icache_read}, 32'd0);
      chk("rst_addr", icache_addr, 32'd0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    end else begin
      if (!p_rdy) begin
        chk("frz_valid", {31'b0, inst_valid}, {31'b0, p_valid});
        chk("frz_read", {31'b0, icache_read}, {31'b0, p_read});
        chk("frz_addr", icache_addr, p_addr);
        if (p_valid) begin
          chk("frz_inst", inst, p_inst);
          chk("frz_pc", inst_pc, p_ipc);
        end
      end
      if (p_read && !(p_ok && p_rdy)) begin
        chk("hold_read", {31'b0, icache_read}, 32'd1);
        chk("hold_addr", icache_addr, p_addr);
      end
      if (p_read && p_ok && p_rdy)
        chk("gap_read", {31'b0, icache_read}, 32'd0);
    end

    if (rst) begin
      sb.delete();
      exp_pc = RESET_PC;
    end else if (rdy) begin
      if (inst_valid && inst_ready && !jump_en) begin
        hs_cnt++;
        chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          ent_t e;
          e = sb.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", inst, e.w);
        end
      end
      if (jump_en) begin
        sb.delete();
        exp_pc = jump_addr;
      end else if (icache_read && icache_ok && icache_addr == exp_pc) begin
        sb.push_back('{pc: exp_pc, w: hash(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
    end

    p_rst   = rst;
    p_rdy   = rdy;
    p_ok    = icache_ok;
    p_read  = icache_read;
    p_addr  = icache_addr;
    p_valid = inst_valid;
    p_inst  = inst;
    p_ipc   = inst_pc;
  end

  // icache model and stimulus; inputs change 1 time unit after posedge
  bit busy = 0;
  int left = 0;
  int jn   = 0;

  task automatic step(input int p_jump, input int p_ready,
                      input int p_rdy, input int lat_min,
                      input int lat_max, input int p_rs);
    rst        = ($urandom_range(999) < p_rs);
    rdy        = ($urandom_range(99) < p_rdy);
    inst_ready = ($urandom_range(99) < p_ready);
    jump_en    = ($urandom_range(999) < p_jump);
    if (jump_en) begin
      jn++;
      jump_addr = (32'(jn) << 16) | ($urandom & 32'h7FFC);
    end
    icache_ok  = 1'b0;
    icache_ans = $urandom;
    if (rst) begin
      busy = 0;
    end else if (rdy && icache_read) begin
      if (!busy) begin
        busy = 1;
        left = $urandom_range(lat_max, lat_min);
      end
      if (left == 0) begin
        icache_ok  = 1'b1;
        icache_ans = hash(icache_addr);
        busy       = 0;
      end else begin
        left--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step(0, 0, 100, 1, 1, 1000);
  endtask

  initial begin
    int h0;
    do_reset();
    chk("reset_read", {31'b0, icache_read}, 32'd0);
    chk("reset_valid", {31'b0, inst_valid}, 32'd0);

    h0 = hs_cnt;
    for (int i = 0; i < 30; i++) step(0, 100, 100, 1, 1, 0);
    chk("hit_progress", {31'b0, (hs_cnt - h0) >= 5}, 32'd1);

    do_reset();
    for (int i = 0; i < 25; i++) step(0, 0, 100, 1, 1, 0);
    chk("full_noread", {31'b0, icache_read}, 32'd0);
    chk("full_valid", {31'b0, inst_valid}, 32'd1);
    chk("full_entries", 32'(sb.size()), 32'd4);
    chk("full_head_pc", inst_pc, RESET_PC);
    h0 = hs_cnt;
    for (int i = 0; i < 30; i++) step(0, 100, 100, 1, 1, 0);
    chk("drain_progress", {31'b0, (hs_cnt - h0) >= 8}, 32'd1);

    for (int i = 0; i < 60; i++) step(0, 100, 100, 10, 10, 0);
    for (int i = 0; i < 60; i++) step(0, 100, 60, 1, 3, 0);
    for (int i = 0; i < 3000; i++) step(60, 60, 85, 0, 4, 3);
    for (int i = 0; i < 400; i++) step(200, 80, 90, 0, 6, 0);

    do_reset();
    chk("end_read", {31'b0, icache_read}, 32'd0);
    chk("end_valid", {31'b0, inst_valid}, 32'd0);
    for (int i = 0; i < 20; i++) step(0, 100, 100, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
